// File: rtl/vid_palette_ctrl.sv
// Palette write-port controller: 4-deep CPU entry FIFO plus range-fill engine, fill has priority.
// Define VID_PALETTE_CTRL_VBLANK_SYNC_EN to hold all commits to vertical blanking.
module vid_palette_ctrl (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [7:0]  req_addr,
  input  logic [15:0] req_data,
  input  logic        fill_start,
  input  logic [7:0]  fill_first,
  input  logic [7:0]  fill_last,
  input  logic [15:0] fill_color,
  output logic        fill_busy,
  input  logic        vblank,
  output logic [2:0]  fifo_level,
  output logic [7:0]  pal_w_addr,
  output logic [15:0] pal_w_data,
  output logic        pal_w_ena
);

  typedef enum logic {S_IDLE, S_FILL} state_t;

  state_t      r_state;
  logic [7:0]  r_fifo_addr [4];
  logic [15:0] r_fifo_data [4];
  logic [1:0]  r_wr_ptr;
  logic [1:0]  r_rd_ptr;
  logic [2:0]  r_level;
  logic [7:0]  r_cursor;
  logic [7:0]  r_last;
  logic [15:0] r_color;
  logic        r_fill_busy;
  logic        r_w_ena;
  logic [7:0]  r_w_addr;
  logic [15:0] r_w_data;

  logic w_commit_ok;
  logic w_full;
  logic w_empty;
  logic w_push;
  logic w_pop;
  logic w_step;
  logic w_fill_go;

`ifdef VID_PALETTE_CTRL_VBLANK_SYNC_EN
  assign w_commit_ok = vblank;
`else
  logic w_unused_vblank;
  assign w_unused_vblank = vblank;
  assign w_commit_ok     = 1'b1;
`endif

  assign w_full    = (r_level == 3'd4);
  assign w_empty   = (r_level == 3'd0);
  assign w_push    = req_valid && !w_full;
  // The FIFO only drains while the fill engine is idle, giving fill strict priority.
  assign w_pop     = w_commit_ok && !w_empty && (r_state == S_IDLE);
  assign w_step    = w_commit_ok && (r_state == S_FILL);
  assign w_fill_go = fill_start && (r_state == S_IDLE);

  assign req_ready  = !w_full;
  assign fifo_level = r_level;
  assign fill_busy  = r_fill_busy;
  assign pal_w_ena  = r_w_ena;
  assign pal_w_addr = r_w_addr;
  assign pal_w_data = r_w_data;

  // Payload storage needs no reset: nothing reads it until a valid push or fill latch.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_fifo_addr[r_wr_ptr] <= req_addr;
      r_fifo_data[r_wr_ptr] <= req_data;
    end
    if (w_fill_go) begin
      r_cursor <= fill_first;
      r_last   <= fill_last;
      r_color  <= fill_color;
    end else if (w_step) begin
      r_cursor <= r_cursor + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_wr_ptr    <= 2'd0;
      r_rd_ptr    <= 2'd0;
      r_level     <= 3'd0;
      r_fill_busy <= 1'b0;
      r_w_ena     <= 1'b0;
      r_w_addr    <= 8'd0;
      r_w_data    <= 16'd0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 2'd1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 2'd1;
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + 3'd1;
        2'b01:   r_level <= r_level - 3'd1;
        default: r_level <= r_level;
      endcase

      r_w_ena <= w_pop || w_step;
      if (w_step) begin
        r_w_addr <= r_cursor;
        r_w_data <= r_color;
      end else if (w_pop) begin
        r_w_addr <= r_fifo_addr[r_rd_ptr];
        r_w_data <= r_fifo_data[r_rd_ptr];
      end

      case (r_state)
        S_IDLE: begin
          if (fill_start) begin
            r_state     <= S_FILL;
            r_fill_busy <= 1'b1;
          end
        end
        S_FILL: begin
          // Leave on the step that emits the last index, so busy drops with that write.
          if (w_step && (r_cursor == r_last)) begin
            r_state     <= S_IDLE;
            r_fill_busy <= 1'b0;
          end
        end
        default: begin
          r_state     <= S_IDLE;
          r_fill_busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_vid_palette_ctrl.sv
// Scoreboard bench for vid_palette_ctrl; expectations follow VID_PALETTE_CTRL_VBLANK_SYNC_EN.
module tb_vid_palette_ctrl;

`ifdef VID_PALETTE_CTRL_VBLANK_SYNC_EN
  localparam bit GATED = 1'b1;
`else
  localparam bit GATED = 1'b0;
`endif

  typedef struct {
    int          cyc;
    logic [7:0]  addr;
    logic [15:0] data;
  } wr_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [7:0]  req_addr = 8'd0;
  logic [15:0] req_data = 16'd0;
  logic        fill_start = 1'b0;
  logic [7:0]  fill_first = 8'd0;
  logic [7:0]  fill_last = 8'd0;
  logic [15:0] fill_color = 16'd0;
  logic        fill_busy;
  logic        vblank = 1'b0;
  logic [2:0]  fifo_level;
  logic [7:0]  pal_w_addr;
  logic [15:0] pal_w_data;
  logic        pal_w_ena;

  wr_t exp_q[$];
  wr_t obs_q[$];
  wr_t mon_w;
  int  cyc = 0;
  int  checks = 0;
  int  errors = 0;

  vid_palette_ctrl dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_addr   (req_addr),
    .req_data   (req_data),
    .fill_start (fill_start),
    .fill_first (fill_first),
    .fill_last  (fill_last),
    .fill_color (fill_color),
    .fill_busy  (fill_busy),
    .vblank     (vblank),
    .fifo_level (fifo_level),
    .pal_w_addr (pal_w_addr),
    .pal_w_data (pal_w_data),
    .pal_w_ena  (pal_w_ena)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  // Every palette write is captured with the number of the edge that produced it.
  always @(negedge clk) begin
    if (pal_w_ena === 1'b1) begin
      mon_w.cyc  = cyc;
      mon_w.addr = pal_w_addr;
      mon_w.data = pal_w_data;
      obs_q.push_back(mon_w);
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_obs(input int n, input int budget);
    for (int i = 0; i < budget && obs_q.size() < n; i++) @(negedge clk);
    repeat (4) @(negedge clk);
  endtask

  task automatic test_reset();
    int  s;
    wr_t ew, ow;
    rst_n = 1'b0;
    for (int i = 0; i < 6; i++) begin
      req_valid  = 1'($urandom_range(0, 1));
      req_addr   = 8'($urandom);
      req_data   = 16'($urandom);
      fill_start = 1'($urandom_range(0, 1));
      fill_first = 8'($urandom);
      fill_last  = 8'($urandom);
      fill_color = 16'($urandom);
      vblank     = 1'($urandom_range(0, 1));
      @(negedge clk);
      checks++;
      if (pal_w_ena !== 1'b0 || fifo_level !== 3'd0 || req_ready !== 1'b1 || fill_busy !== 1'b0) begin
        errors++;
        $display("FAIL reset_hold: ena=%b level=%0d ready=%b busy=%b, expected 0/0/1/0",
                 pal_w_ena, fifo_level, req_ready, fill_busy);
      end
    end
    step();
    req_valid = 1'b0; fill_start = 1'b0; vblank = 1'b1; rst_n = 1'b1;
    repeat (10) @(negedge clk);
    checks++;
    if (obs_q.size() != 0) begin
      errors++;
      $display("FAIL reset_release: %0d writes after release, expected 0", obs_q.size());
    end
    checks++;
    if (pal_w_addr !== 8'd0 || pal_w_data !== 16'd0) begin
      errors++;
      $display("FAIL reset_outputs: addr=%02h data=%04h, expected 00/0000", pal_w_addr, pal_w_data);
    end
    obs_q.delete();

    step();
    s = cyc;
    fill_first = 8'd0; fill_last = 8'd255; fill_color = 16'hBEEF; fill_start = 1'b1;
    step();
    fill_start = 1'b0;
    while (cyc < s + 21) step();
    rst_n = 1'b0;
    #1;
    checks++;
    if (pal_w_ena !== 1'b0 || pal_w_addr !== 8'd0 || pal_w_data !== 16'd0 || fill_busy !== 1'b0 ||
        fifo_level !== 3'd0 || req_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_async: ena=%b addr=%02h data=%04h busy=%b level=%0d ready=%b, expected 0/00/0000/0/0/1",
               pal_w_ena, pal_w_addr, pal_w_data, fill_busy, fifo_level, req_ready);
    end
    for (int i = 0; i < 19; i++) exp_q.push_back('{s + 2 + i, 8'(i), 16'hBEEF});
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (12) @(negedge clk);
    while (exp_q.size() > 0) begin
      ew = exp_q.pop_front();
      checks++;
      if (obs_q.size() == 0) begin
        errors++;
        $display("FAIL reset_fill_missing: no write seen, expected %02h/%04h", ew.addr, ew.data);
      end else begin
        ow = obs_q.pop_front();
        if (ow.addr !== ew.addr || ow.data !== ew.data || ow.cyc != ew.cyc) begin
          errors++;
          $display("FAIL reset_fill_write: got %02h/%04h at cycle %0d, expected %02h/%04h at cycle %0d",
                   ow.addr, ow.data, ow.cyc, ew.addr, ew.data, ew.cyc);
        end
      end
    end
    checks++;
    if (obs_q.size() != 0) begin
      errors++;
      $display("FAIL reset_fill_extra: %0d writes after mid-fill reset, expected 0", obs_q.size());
      obs_q.delete();
    end
  endtask

  task automatic test_back_to_back();
    wr_t ew, ow;
    vblank = 1'b1;
    step();
    for (int i = 0; i < 6; i++) begin
      req_valid = 1'b1;
      req_addr  = 8'(8'h30 + i);
      req_data  = 16'($urandom);
      exp_q.push_back('{cyc + 1 + 1, req_addr, req_data});
      step();
    end
    req_valid = 1'b0;
    checks++;
    if (fifo_level !== 3'd1 || req_ready !== 1'b1) begin
      errors++;
      $display("FAIL b2b_level: level=%0d ready=%b, expected 1/1", fifo_level, req_ready);
    end
    wait_obs(6, 40);
    while (exp_q.size() > 0) begin
      ew = exp_q.pop_front();
      checks++;
      if (obs_q.size() == 0) begin
        errors++;
        $display("FAIL b2b_missing: no write seen, expected %02h/%04h", ew.addr, ew.data);
      end else begin
        ow = obs_q.pop_front();
        if (ow.addr !== ew.addr || ow.data !== ew.data || ow.cyc != ew.cyc) begin
          errors++;
          $display("FAIL b2b_write: got %02h/%04h at cycle %0d, expected %02h/%04h at cycle %0d",
                   ow.addr, ow.data, ow.cyc, ew.addr, ew.data, ew.cyc);
        end
      end
    end
    checks++;
    if (obs_q.size() != 0) begin
      errors++;
      $display("FAIL b2b_extra: %0d unexpected writes, expected 0", obs_q.size());
      obs_q.delete();
    end
  endtask

  task automatic test_latency();
    int  k, r;
    wr_t ew, ow;
    vblank = 1'b0;
    step();
    req_valid = 1'b1; req_addr = 8'h10; req_data = 16'h5555;
    step();
    k = cyc;
    req_valid = 1'b0;
    step();
    step();
    r = cyc;
    vblank = 1'b1;
    exp_q.push_back('{GATED ? r + 1 : k + 1, 8'h10, 16'h5555});
    wait_obs(1, 20);
    while (exp_q.size() > 0) begin
      ew = exp_q.pop_front();
      checks++;
      if (obs_q.size() == 0) begin
        errors++;
        $display("FAIL latency_missing: no write seen, expected %02h/%04h", ew.addr, ew.data);
      end else begin
        ow = obs_q.pop_front();
        if (ow.addr !== ew.addr || ow.data !== ew.data || ow.cyc != ew.cyc) begin
          errors++;
          $display("FAIL latency_write: got %02h/%04h at cycle %0d, expected %02h/%04h at cycle %0d",
                   ow.addr, ow.data, ow.cyc, ew.addr, ew.data, ew.cyc);
        end
      end
    end
    checks++;
    if (obs_q.size() != 0) begin
      errors++;
      $display("FAIL latency_extra: %0d unexpected writes, expected 0", obs_q.size());
      obs_q.delete();
    end
  endtask

  task automatic test_vblank_gating();
    logic [7:0]  a [4];
    logic [15:0] d [4];
    int          e [4];
    int          r;
    wr_t         ew, ow;
    a = '{8'h05, 8'h06, 8'h07, 8'h08};
    d = '{16'h1234, 16'hABCD, 16'h0F0F, 16'hF000};
    vblank = 1'b0;
    step();
    for (int i = 0; i < 4; i++) begin
      req_valid = 1'b1; req_addr = a[i]; req_data = d[i];
      step();
      e[i] = cyc;
    end
    req_valid = 1'b0;
    checks++;
    if (fifo_level !== 3'(GATED ? 4 : 1)) begin
      errors++;
      $display("FAIL gating_level: level=%0d, expected %0d", fifo_level, GATED ? 4 : 1);
    end
    checks++;
    if (req_ready !== !GATED) begin
      errors++;
      $display("FAIL gating_ready: ready=%b, expected %b", req_ready, !GATED);
    end
    step();
    step();
    r = cyc;
    checks++;
    if (obs_q.size() != (GATED ? 0 : 4)) begin
      errors++;
      $display("FAIL gating_hold: %0d writes before vblank, expected %0d", obs_q.size(), GATED ? 0 : 4);
    end
    vblank = 1'b1; req_valid = 1'b1; req_addr = 8'h99; req_data = 16'h9999;
    step();
    req_valid = 1'b0;
    for (int i = 0; i < 4; i++) exp_q.push_back('{GATED ? r + 1 + i : e[i] + 1, a[i], d[i]});
    if (!GATED) exp_q.push_back('{r + 2, 8'h99, 16'h9999});
    wait_obs(GATED ? 4 : 5, 40);
    while (exp_q.size() > 0) begin
      ew = exp_q.pop_front();
      checks++;
      if (obs_q.size() == 0) begin
        errors++;
        $display("FAIL gating_missing: no write seen, expected %02h/%04h", ew.addr, ew.data);
      end else begin
        ow = obs_q.pop_front();
        if (ow.addr !== ew.addr || ow.data !== ew.data || ow.cyc != ew.cyc) begin
          errors++;
          $display("FAIL gating_write: got %02h/%04h at cycle %0d, expected %02h/%04h at cycle %0d",
                   ow.addr, ow.data, ow.cyc, ew.addr, ew.data, ew.cyc);
        end
      end
    end
    checks++;
    if (obs_q.size() != 0) begin
      errors++;
      $display("FAIL gating_extra: %0d unexpected writes, expected 0", obs_q.size());
      obs_q.delete();
    end
  endtask

  task automatic test_fill_wrap();
    int  s;
    int  busy;
    wr_t ew, ow;
    vblank = 1'b1;
    step();
    s = cyc;
    fill_first = 8'd250; fill_last = 8'd3; fill_color = 16'h07E0; fill_start = 1'b1;
    step();
    fill_start = 1'b0;
    for (int i = 0; i < 10; i++) exp_q.push_back('{s + 2 + i, 8'(250 + i), 16'h07E0});
    busy = 0;
    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      if (fill_busy === 1'b1) busy++;
      if (cyc == s + 11) begin
        checks++;
        if (pal_w_ena !== 1'b1 || fill_busy !== 1'b0) begin
          errors++;
          $display("FAIL wrap_busy_fall: ena=%b busy=%b on last write, expected 1/0", pal_w_ena, fill_busy);
        end
      end
    end
    checks++;
    if (busy != 10) begin
      errors++;
      $display("FAIL wrap_busy_len: busy for %0d cycles, expected 10", busy);
    end
    while (exp_q.size() > 0) begin
      ew = exp_q.pop_front();
      checks++;
      if (obs_q.size() == 0) begin
        errors++;
        $display("FAIL wrap_missing: no write seen, expected %02h/%04h", ew.addr, ew.data);
      end else begin
        ow = obs_q.pop_front();
        if (ow.addr !== ew.addr || ow.data !== ew.data || ow.cyc != ew.cyc) begin
          errors++;
          $display("FAIL wrap_write: got %02h/%04h at cycle %0d, expected %02h/%04h at cycle %0d",
                   ow.addr, ow.data, ow.cyc, ew.addr, ew.data, ew.cyc);
        end
      end
    end
    checks++;
    if (obs_q.size() != 0) begin
      errors++;
      $display("FAIL wrap_extra: %0d unexpected writes, expected 0", obs_q.size());
      obs_q.delete();
    end
  endtask

  task automatic test_fill_single_and_ignore();
    int  s;
    wr_t ew, ow;
    vblank = 1'b1;
    step();
    s = cyc;
    fill_first = 8'd10; fill_last = 8'd13; fill_color = 16'h3333; fill_start = 1'b1;
    step();
    fill_first = 8'd100; fill_last = 8'd101; fill_color = 16'h4444;
    step();
    fill_start = 1'b0;
    for (int i = 0; i < 4; i++) exp_q.push_back('{s + 2 + i, 8'(10 + i), 16'h3333});
    repeat (6) step();
    s = cyc;
    fill_first = 8'h42; fill_last = 8'h42; fill_color = 16'h5A5A; fill_start = 1'b1;
    step();
    fill_start = 1'b0;
    exp_q.push_back('{s + 2, 8'h42, 16'h5A5A});
    wait_obs(5, 20);
    while (exp_q.size() > 0) begin
      ew = exp_q.pop_front();
      checks++;
      if (obs_q.size() == 0) begin
        errors++;
        $display("FAIL single_missing: no write seen, expected %02h/%04h", ew.addr, ew.data);
      end else begin
        ow = obs_q.pop_front();
        if (ow.addr !== ew.addr || ow.data !== ew.data || ow.cyc != ew.cyc) begin
          errors++;
          $display("FAIL single_write: got %02h/%04h at cycle %0d, expected %02h/%04h at cycle %0d",
                   ow.addr, ow.data, ow.cyc, ew.addr, ew.data, ew.cyc);
        end
      end
    end
    checks++;
    if (obs_q.size() != 0) begin
      errors++;
      $display("FAIL single_extra: %0d unexpected writes, expected 0", obs_q.size());
      obs_q.delete();
    end
  endtask

  task automatic test_priority();
    wr_t ew, ow;
    vblank = 1'b0;
    step();
    req_valid = 1'b1; req_addr = 8'h20; req_data = 16'hAAAA;
    step();
    req_addr = 8'h21; req_data = 16'hBBBB;
    step();
    req_valid = 1'b0;
    fill_first = 8'd0; fill_last = 8'd3; fill_color = 16'h1111; fill_start = 1'b1;
    step();
    fill_start = 1'b0;
    step();
    step();
    checks++;
    if (fifo_level !== 3'(GATED ? 2 : 0) || fill_busy !== 1'b1) begin
      errors++;
      $display("FAIL prio_pending: level=%0d busy=%b, expected %0d/1", fifo_level, fill_busy, GATED ? 2 : 0);
    end
    if (!GATED) begin
      exp_q.push_back('{0, 8'h20, 16'hAAAA});
      exp_q.push_back('{0, 8'h21, 16'hBBBB});
    end
    for (int i = 0; i < 4; i++) exp_q.push_back('{0, 8'(i), 16'h1111});
    if (GATED) begin
      exp_q.push_back('{0, 8'h20, 16'hAAAA});
      exp_q.push_back('{0, 8'h21, 16'hBBBB});
    end
    vblank = 1'b1;
    wait_obs(6, 40);
    while (exp_q.size() > 0) begin
      ew = exp_q.pop_front();
      checks++;
      if (obs_q.size() == 0) begin
        errors++;
        $display("FAIL prio_missing: no write seen, expected %02h/%04h", ew.addr, ew.data);
      end else begin
        ow = obs_q.pop_front();
        if (ow.addr !== ew.addr || ow.data !== ew.data) begin
          errors++;
          $display("FAIL prio_write: got %02h/%04h, expected %02h/%04h", ow.addr, ow.data, ew.addr, ew.data);
        end
      end
    end
    checks++;
    if (obs_q.size() != 0) begin
      errors++;
      $display("FAIL prio_extra: %0d unexpected writes, expected 0", obs_q.size());
      obs_q.delete();
    end
  endtask

  task automatic test_vblank_drop();
    int  s, r;
    wr_t ew, ow;
    vblank = 1'b1;
    step();
    s = cyc;
    fill_first = 8'd0; fill_last = 8'd255; fill_color = 16'hC0DE; fill_start = 1'b1;
    step();
    fill_start = 1'b0;
    while (cyc < s + 101) step();
    vblank = 1'b0;
    repeat (20) step();
    checks++;
    if (obs_q.size() != (GATED ? 100 : 119)) begin
      errors++;
      $display("FAIL drop_count: %0d writes while paused, expected %0d", obs_q.size(), GATED ? 100 : 119);
    end
    checks++;
    if (fill_busy !== 1'b1) begin
      errors++;
      $display("FAIL drop_busy: busy=%b while paused, expected 1", fill_busy);
    end
    r = cyc;
    vblank = 1'b1;
    for (int i = 0; i < 256; i++)
      exp_q.push_back('{(GATED && i >= 100) ? r + 1 + (i - 100) : s + 2 + i, 8'(i), 16'hC0DE});
    wait_obs(256, 400);
    checks++;
    if (fill_busy !== 1'b0) begin
      errors++;
      $display("FAIL drop_done: busy=%b after full range, expected 0", fill_busy);
    end
    while (exp_q.size() > 0) begin
      ew = exp_q.pop_front();
      checks++;
      if (obs_q.size() == 0) begin
        errors++;
        $display("FAIL drop_missing: no write seen, expected %02h/%04h", ew.addr, ew.data);
      end else begin
        ow = obs_q.pop_front();
        if (ow.addr !== ew.addr || ow.data !== ew.data || ow.cyc != ew.cyc) begin
          errors++;
          $display("FAIL drop_write: got %02h/%04h at cycle %0d, expected %02h/%04h at cycle %0d",
                   ow.addr, ow.data, ow.cyc, ew.addr, ew.data, ew.cyc);
        end
      end
    end
    checks++;
    if (obs_q.size() != 0) begin
      errors++;
      $display("FAIL drop_extra: %0d unexpected writes, expected 0", obs_q.size());
      obs_q.delete();
    end
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_latency();
    test_vblank_gating();
    test_fill_wrap();
    test_fill_single_and_ignore();
    test_priority();
    test_vblank_drop();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
